mux_tree_pipelined: RTL and testbench

- Parametrised N-to-1 registered selector for wide record streams, e.g. particle position/force words.
- Replaces hand-built trees of fixed 4:1 muxes.
- Builds a pipelined radix-4 reduction tree internally.
- Selects the source by external index or by an internal round-robin arbiter over the valid inputs.
- Emits the winning index alongside the data, so downstream logic knows the origin.

---
 rtl/mux_tree_pipelined.sv | 124 ++++++++++++
 tb/tb_mux_tree_pipelined.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_tree_pipelined.sv
// Registered N-to-1 record selector: grant stage (external index or round-robin)
// feeding a pipelined radix-4 reduction tree; the winning index travels with the data.
module mux_tree_pipelined #(
   parameter int unsigned DATA_WIDTH      = 96,
   parameter int unsigned NUM_INPUT_PORTS = 16,
   parameter int unsigned SEL_WIDTH       = 4,
   parameter int unsigned TREE_LEVELS     = 2
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  rr_mode,
   input  logic [SEL_WIDTH-1:0]                  sel,
   input  logic [NUM_INPUT_PORTS-1:0]            in_valid,
   input  logic [NUM_INPUT_PORTS*DATA_WIDTH-1:0] in,
   output logic [NUM_INPUT_PORTS-1:0]            in_grant,
   output logic [DATA_WIDTH-1:0]                 out,
   output logic [SEL_WIDTH-1:0]                  out_sel,
   output logic                                  out_valid
);

   localparam int unsigned LEAVES = 1 << (2 * TREE_LEVELS);
   localparam int unsigned IW     = 2 * TREE_LEVELS;

   typedef logic [DATA_WIDTH-1:0] rec_t;

   logic [SEL_WIDTH-1:0] last_grant_q, last_grant_d;
   logic [SEL_WIDTH-1:0] winner;
   logic                 grant_ok;

   rec_t                 in_rec [NUM_INPUT_PORTS];
   rec_t                 in_q   [NUM_INPUT_PORTS];
   logic [SEL_WIDTH-1:0] idx_q  [TREE_LEVELS+1];
   logic [IW-1:0]        idx_w  [TREE_LEVELS];
   logic [TREE_LEVELS:0] vld_q;
   rec_t                 lvl    [TREE_LEVELS][LEAVES];
   rec_t                 node_q [TREE_LEVELS][LEAVES];
   rec_t                 node_d [TREE_LEVELS][LEAVES];

   always_comb begin
      int unsigned          k;
      logic [SEL_WIDTH-1:0] ks;
      k        = 0;
      ks       = '0;
      winner   = '0;
      grant_ok = 1'b0;
      if (rr_mode) begin
         // Scan last_grant+1 upward with wraparound; first valid channel wins.
         for (int unsigned i = 0; i < NUM_INPUT_PORTS; i++) begin
            k  = (32'(last_grant_q) + 1 + i) % NUM_INPUT_PORTS;
            ks = SEL_WIDTH'(k);
            if (!grant_ok && in_valid[ks]) begin
               grant_ok = 1'b1;
               winner   = ks;
            end
         end
      end else if (32'(sel) < NUM_INPUT_PORTS) begin
         winner   = sel;
         grant_ok = in_valid[sel];
      end
   end

   always_comb begin
      in_grant = '0;
      if (grant_ok) in_grant[winner] = 1'b1;
   end

   assign last_grant_d = (rr_mode && grant_ok) ? winner : last_grant_q;

   for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
      if (k < NUM_INPUT_PORTS) begin : g_used
         assign in_rec[k]  = in[k*DATA_WIDTH +: DATA_WIDTH];
         assign lvl[0][k]  = in_q[k];
      end else begin : g_pad
         assign lvl[0][k]  = '0;
      end
   end

   // Level l resolves index bits [2l-1:2l-2]; only the first LEAVES/4^l nodes are live.
   for (genvar l = 1; l <= TREE_LEVELS; l++) begin : g_lvl
      logic [1:0] s;
      assign idx_w[l-1] = IW'(idx_q[l-1]);
      assign s          = idx_w[l-1][2*(l-1) +: 2];
      for (genvar k = 0; k < LEAVES; k++) begin : g_node
         if (l < TREE_LEVELS) begin : g_fwd
            assign lvl[l][k] = node_q[l-1][k];
         end
         if (k < (LEAVES >> (2*l))) begin : g_mux
            assign node_d[l-1][k] = s[1] ? (s[0] ? lvl[l-1][4*k+3] : lvl[l-1][4*k+2])
                                         : (s[0] ? lvl[l-1][4*k+1] : lvl[l-1][4*k]);
         end else begin : g_zero
            assign node_d[l-1][k] = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= SEL_WIDTH'(NUM_INPUT_PORTS - 1);
         in_q         <= '{default: '0};
         idx_q        <= '{default: '0};
         vld_q        <= '0;
         node_q       <= '{default: '0};
      end else begin
         last_grant_q <= last_grant_d;
         vld_q        <= {vld_q[TREE_LEVELS-1:0], grant_ok};
         if (grant_ok) begin
            in_q     <= in_rec;
            idx_q[0] <= winner;
         end
         // Stages load only behind a valid record, so out/out_sel hold across bubbles.
         for (int unsigned l = 1; l <= TREE_LEVELS; l++) begin
            if (vld_q[l-1]) begin
               idx_q[l]    <= idx_q[l-1];
               node_q[l-1] <= node_d[l-1];
            end
         end
      end
   end

   assign out       = node_q[TREE_LEVELS-1][0];
   assign out_sel   = idx_q[TREE_LEVELS];
   assign out_valid = vld_q[TREE_LEVELS];

endmodule

// File: tb/tb_mux_tree_pipelined.sv
// Self-checking bench for mux_tree_pipelined: default 16-port instance against a
// grant-order reference model, plus a 6-port instance for the non-power-of-4 case.
module tb_mux_tree_pipelined;

   localparam int W   = 96;
   localparam int N   = 16;
   localparam int SW  = 4;
   localparam int N2  = 6;
   localparam int SW2 = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          rr_mode;
   logic [SW-1:0] sel;
   logic [N-1:0]  in_valid;
   logic [N*W-1:0] in_bus;
   logic [N-1:0]  in_grant;
   logic [W-1:0]  out;
   logic [SW-1:0] out_sel;
   logic          out_valid;

   logic           b_rr_mode;
   logic [SW2-1:0] b_sel;
   logic [N2-1:0]  b_in_valid;
   logic [N2*W-1:0] b_in_bus;
   logic [N2-1:0]  b_in_grant;
   logic [W-1:0]   b_out;
   logic [SW2-1:0] b_out_sel;
   logic           b_out_valid;

   mux_tree_pipelined #(.DATA_WIDTH(W), .NUM_INPUT_PORTS(N), .SEL_WIDTH(SW), .TREE_LEVELS(2)) u_dut (
      .clk(clk), .rst(rst), .rr_mode(rr_mode), .sel(sel), .in_valid(in_valid), .in(in_bus),
      .in_grant(in_grant), .out(out), .out_sel(out_sel), .out_valid(out_valid));

   mux_tree_pipelined #(.DATA_WIDTH(W), .NUM_INPUT_PORTS(N2), .SEL_WIDTH(SW2), .TREE_LEVELS(2)) u_dut6 (
      .clk(clk), .rst(rst), .rr_mode(b_rr_mode), .sel(b_sel), .in_valid(b_in_valid), .in(b_in_bus),
      .in_grant(b_in_grant), .out(b_out), .out_sel(b_out_sel), .out_valid(b_out_valid));

   typedef struct {
      logic [W-1:0] d;
      int           idx;
      int           due;
   } exp_t;

   logic [W-1:0] rec  [N];
   logic [W-1:0] brec [N2];
   exp_t         pend [$];
   logic [W-1:0] last_out;
   int           last_sel;
   int           ptr;
   int           cyc;
   int           errors = 0;
   int           checks = 0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_rec();
      return {$urandom, $urandom, $urandom};
   endfunction

   // Reference grant rule: -1 means no grant this cycle.
   function automatic int model_winner(input bit rr, input int s, input logic [N-1:0] v, input int p);
      if (rr) begin
         for (int i = 1; i <= N; i++)
            if (v[(p + i) % N]) return (p + i) % N;
         return -1;
      end
      if (s < N && v[s]) return s;
      return -1;
   endfunction

   task automatic check_out();
      exp_t e;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         e = pend.pop_front();
         check("out_valid", W'(out_valid), W'(1));
         check("out", out, e.d);
         check("out_sel", W'(out_sel), W'(e.idx));
         last_out = e.d;
         last_sel = e.idx;
      end else begin
         check("out_valid_idle", W'(out_valid), W'(0));
         check("out_hold", out, last_out);
         check("out_sel_hold", W'(out_sel), W'(last_sel));
      end
   endtask

   // Called just after a negedge with inputs set; ends at the next negedge.
   task automatic do_cycle();
      int   w;
      exp_t e;
      for (int k = 0; k < N; k++) in_bus[k*W +: W] = rec[k];
      #1;
      w = model_winner(rr_mode, int'(sel), in_valid, ptr);
      check("in_grant", W'(in_grant), (w >= 0) ? (W'(1) << w) : W'(0));
      @(posedge clk);
      cyc++;
      if (w >= 0) begin
         e.d   = rec[w];
         e.idx = w;
         e.due = cyc + 2;
         pend.push_back(e);
         if (rr_mode) ptr = w;
      end
      @(negedge clk);
      check_out();
   endtask

   task automatic model_reset();
      pend.delete();
      last_out = '0;
      last_sel = 0;
      ptr      = N - 1;
   endtask

   initial begin
      rst = 1'b1;
      rr_mode = 1'b0; sel = '0; in_valid = '0; in_bus = '0;
      b_rr_mode = 1'b0; b_sel = '0; b_in_valid = '0; b_in_bus = '0;
      for (int k = 0; k < N; k++) rec[k] = '0;
      for (int k = 0; k < N2; k++) brec[k] = rand_rec();
      cyc = 0;
      model_reset();
      #2;
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_out", out, W'(0));
      check("rst_out_sel", W'(out_sel), W'(0));
      check("rst_b_out_valid", W'(b_out_valid), W'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // External select of channel 5, one record, then idle
      for (int k = 0; k < N; k++) rec[k] = rand_rec();
      rec[5] = 96'hA5;
      sel = 4'd5; in_valid = 16'h0020;
      do_cycle();
      in_valid = '0;
      repeat (4) do_cycle();

      // External select of an invalid channel: bubble, output holds
      sel = 4'd3; in_valid = 16'hFFF7;
      repeat (2) do_cycle();
      in_valid = '0;
      repeat (3) do_cycle();

      // Round-robin over channels 0, 4, 15
      rr_mode = 1'b1; in_valid = 16'h8011;
      repeat (6) begin
         for (int k = 0; k < N; k++) rec[k] = rand_rec();
         do_cycle();
      end
      in_valid = '0;
      repeat (3) do_cycle();

      // Wrap scan back to the last granted channel, then no requests
      in_valid = 16'h8000;
      do_cycle();
      in_valid = '0;
      repeat (4) do_cycle();

      // Randomised mix of modes, selects and valid patterns
      repeat (60) begin
         for (int k = 0; k < N; k++) rec[k] = rand_rec();
         rr_mode  = 1'($urandom_range(0, 1));
         sel      = SW'($urandom);
         in_valid = ($urandom_range(0, 3) == 0) ? N'($urandom) & N'($urandom) : N'($urandom);
         do_cycle();
      end
      in_valid = '0;
      repeat (3) do_cycle();

      // Asynchronous reset with records in flight
      rr_mode = 1'b1; in_valid = '1;
      repeat (4) begin
         for (int k = 0; k < N; k++) rec[k] = rand_rec();
         do_cycle();
      end
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", W'(out_valid), W'(0));
      check("arst_out", out, W'(0));
      check("arst_out_sel", W'(out_sel), W'(0));
      in_valid = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (4) do_cycle();
      in_valid = '1;
      for (int k = 0; k < N; k++) rec[k] = rand_rec();
      do_cycle();
      in_valid = '0;
      repeat (3) do_cycle();

      // Six-port instance: out-of-range select, then channel 5
      for (int k = 0; k < N2; k++) b_in_bus[k*W +: W] = brec[k];
      b_sel = 3'd7; b_in_valid = 6'h3F;
      #1;
      check("b_grant_oor", W'(b_in_grant), W'(0));
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
         check("b_valid_oor", W'(b_out_valid), W'(0));
      end
      b_sel = 3'd5;
      #1;
      check("b_grant5", W'(b_in_grant), W'(6'h20));
      @(posedge clk);
      @(negedge clk);
      b_in_valid = '0;
      check("b_lat1", W'(b_out_valid), W'(0));
      @(negedge clk);
      check("b_lat2", W'(b_out_valid), W'(0));
      @(negedge clk);
      check("b_lat3_valid", W'(b_out_valid), W'(1));
      check("b_out", b_out, brec[5]);
      check("b_out_sel", W'(b_out_sel), W'(5));
      @(negedge clk);
      check("b_after_valid", W'(b_out_valid), W'(0));
      check("b_after_hold", b_out, brec[5]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
